axil_cfg_master: RTL

- Single-outstanding AXI4-Lite initiator that turns a simple request/response command interface into cfg_* bus transactions.
- Drives the peripheral configuration bus (e.g. the gpio register block) from a CPU-side sequencer or debug bridge.
- Issues one read or one write at a time.
- Returns the read data and the bus response code, plus a timeout flag if the responder never answers.

---
 rtl/axil_cfg_master.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_cfg_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axil_cfg_master                                           |
// | Purpose  : Single-outstanding AXI4-Lite initiator. Converts a simple |
// |            request/response command into one cfg_* bus transaction,  |
// |            returning read data, response code and a timeout flag.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module axil_cfg_master #(
   parameter int          ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int          TO_W           = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // command side
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   input  logic [3:0]        req_wstrb_i,
   // response side
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [31:0]       resp_rdata_o,
   output logic [1:0]        resp_code_o,
   output logic              resp_timeout_o,
   // write address channel
   output logic              cfg_awvalid_o,
   input  logic              cfg_awready_i,
   output logic [ADDR_W-1:0] cfg_awaddr_o,
   // write data channel
   output logic              cfg_wvalid_o,
   input  logic              cfg_wready_i,
   output logic [31:0]       cfg_wdata_o,
   output logic [3:0]        cfg_wstrb_o,
   // write response channel
   input  logic              cfg_bvalid_i,
   output logic              cfg_bready_o,
   input  logic [1:0]        cfg_bresp_i,
   // read address channel
   output logic              cfg_arvalid_o,
   input  logic              cfg_arready_i,
   output logic [ADDR_W-1:0] cfg_araddr_o,
   // read data channel
   input  logic              cfg_rvalid_i,
   output logic              cfg_rready_o,
   input  logic [31:0]       cfg_rdata_i,
   input  logic [1:0]        cfg_rresp_i
);

   // Timeout disabled when TIMEOUT_CYCLES is zero. The counter starts at 0
   // on state entry, so the abort fires on the cycle the count equals
   // TIMEOUT_CYCLES-1, i.e. after exactly TIMEOUT_CYCLES wait cycles.
   localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam int unsigned     TO_LIMIT = TO_EN ? (TIMEOUT_CYCLES - 1) : 0;
   localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_LIMIT);
   localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
   localparam logic [1:0]      RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_WR_B = 3'd2,
      ST_RD_A = 3'd3,
      ST_RD_R = 3'd4,
      ST_RESP = 3'd5
   } state_t;

   state_t            state_q,        state_d;
   logic              req_ready_q,    req_ready_d;
   logic              resp_valid_q,   resp_valid_d;
   logic [31:0]       resp_rdata_q,   resp_rdata_d;
   logic [1:0]        resp_code_q,    resp_code_d;
   logic              resp_timeout_q, resp_timeout_d;
   logic              awvalid_q,      awvalid_d;
   logic [ADDR_W-1:0] awaddr_q,       awaddr_d;
   logic              wvalid_q,       wvalid_d;
   logic [31:0]       wdata_q,        wdata_d;
   logic [3:0]        wstrb_q,        wstrb_d;
   logic              bready_q,       bready_d;
   logic              arvalid_q,      arvalid_d;
   logic [ADDR_W-1:0] araddr_q,       araddr_d;
   logic              rready_q,       rready_d;
   logic [TO_W-1:0]   to_cnt_q,       to_cnt_d;

   logic w_wait_state;
   logic w_to_expire;
   logic w_aw_done;
   logic w_w_done;
   logic w_abort;

   assign w_wait_state = (state_q == ST_WR)   || (state_q == ST_WR_B) ||
                         (state_q == ST_RD_A) || (state_q == ST_RD_R);
   assign w_to_expire  = TO_EN && w_wait_state && (to_cnt_q == TO_LAST);
   // A channel is done once its valid has been accepted; the valid register
   // is low in WR only after its handshake.
   assign w_aw_done    = !awvalid_q || cfg_awready_i;
   assign w_w_done     = !wvalid_q  || cfg_wready_i;

   // State register and all registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_IDLE;
         req_ready_q    <= 1'b1;
         resp_valid_q   <= 1'b0;
         resp_rdata_q   <= '0;
         resp_code_q    <= '0;
         resp_timeout_q <= 1'b0;
         awvalid_q      <= 1'b0;
         awaddr_q       <= '0;
         wvalid_q       <= 1'b0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
         bready_q       <= 1'b0;
         arvalid_q      <= 1'b0;
         araddr_q       <= '0;
         rready_q       <= 1'b0;
         to_cnt_q       <= '0;
      end else begin
         state_q        <= state_d;
         req_ready_q    <= req_ready_d;
         resp_valid_q   <= resp_valid_d;
         resp_rdata_q   <= resp_rdata_d;
         resp_code_q    <= resp_code_d;
         resp_timeout_q <= resp_timeout_d;
         awvalid_q      <= awvalid_d;
         awaddr_q       <= awaddr_d;
         wvalid_q       <= wvalid_d;
         wdata_q        <= wdata_d;
         wstrb_q        <= wstrb_d;
         bready_q       <= bready_d;
         arvalid_q      <= arvalid_d;
         araddr_q       <= araddr_d;
         rready_q       <= rready_d;
         to_cnt_q       <= to_cnt_d;
      end
   end

   // Next-state and next-output logic for the transaction sequencer
   always_comb begin
      state_d        = state_q;
      req_ready_d    = req_ready_q;
      resp_valid_d   = resp_valid_q;
      resp_rdata_d   = resp_rdata_q;
      resp_code_d    = resp_code_q;
      resp_timeout_d = resp_timeout_q;
      awvalid_d      = awvalid_q;
      awaddr_d       = awaddr_q;
      wvalid_d       = wvalid_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      bready_d       = bready_q;
      arvalid_d      = arvalid_q;
      araddr_d       = araddr_q;
      rready_d       = rready_q;
      to_cnt_d       = to_cnt_q;
      w_abort        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && req_ready_q) begin
               req_ready_d    = 1'b0;
               resp_timeout_d = 1'b0;
               if (req_write_i) begin
                  awaddr_d  = req_addr_i;
                  wdata_d   = req_wdata_i;
                  wstrb_d   = req_wstrb_i;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = ST_WR;
               end else begin
                  araddr_d  = req_addr_i;
                  arvalid_d = 1'b1;
                  state_d   = ST_RD_A;
               end
            end
         end

         ST_WR: begin
            // AW and W retire independently; each valid drops after its own
            // handshake and stays low for the rest of the transaction.
            if (awvalid_q && cfg_awready_i) awvalid_d = 1'b0;
            if (wvalid_q  && cfg_wready_i)  wvalid_d  = 1'b0;
            if (w_aw_done && w_w_done) begin
               bready_d = 1'b1;
               state_d  = ST_WR_B;
            end else if (w_to_expire) begin
               w_abort = 1'b1;
            end
         end

         ST_WR_B: begin
            if (cfg_bvalid_i && bready_q) begin
               bready_d     = 1'b0;
               resp_code_d  = cfg_bresp_i;
               resp_rdata_d = '0;
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end else if (w_to_expire) begin
               w_abort = 1'b1;
            end
         end

         ST_RD_A: begin
            if (arvalid_q && cfg_arready_i) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_R;
            end else if (w_to_expire) begin
               w_abort = 1'b1;
            end
         end

         ST_RD_R: begin
            if (cfg_rvalid_i && rready_q) begin
               rready_d     = 1'b0;
               resp_rdata_d = cfg_rdata_i;
               resp_code_d  = cfg_rresp_i;
               resp_valid_d = 1'b1;
               state_d      = ST_RESP;
            end else if (w_to_expire) begin
               w_abort = 1'b1;
            end
         end

         ST_RESP: begin
            // Response held stable until consumed
            if (resp_ready_i) begin
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = ST_IDLE;
            end
         end

         default: begin
            state_d      = ST_IDLE;
            req_ready_d  = 1'b1;
            resp_valid_d = 1'b0;
            awvalid_d    = 1'b0;
            wvalid_d     = 1'b0;
            bready_d     = 1'b0;
            arvalid_d    = 1'b0;
            rready_d     = 1'b0;
         end
      endcase

      // Abort: release every bus handshake and report a synthetic SLVERR
      if (w_abort) begin
         awvalid_d      = 1'b0;
         wvalid_d       = 1'b0;
         bready_d       = 1'b0;
         arvalid_d      = 1'b0;
         rready_d       = 1'b0;
         resp_valid_d   = 1'b1;
         resp_rdata_d   = '0;
         resp_code_d    = RESP_SLVERR;
         resp_timeout_d = 1'b1;
         state_d        = ST_RESP;
      end

      // Wait counter restarts on every state change
      if (TO_EN && w_wait_state && (state_d == state_q)) begin
         to_cnt_d = to_cnt_q + TO_ONE;
      end else begin
         to_cnt_d = '0;
      end
   end

   assign req_ready_o    = req_ready_q;
   assign resp_valid_o   = resp_valid_q;
   assign resp_rdata_o   = resp_rdata_q;
   assign resp_code_o    = resp_code_q;
   assign resp_timeout_o = resp_timeout_q;
   assign cfg_awvalid_o  = awvalid_q;
   assign cfg_awaddr_o   = awaddr_q;
   assign cfg_wvalid_o   = wvalid_q;
   assign cfg_wdata_o    = wdata_q;
   assign cfg_wstrb_o    = wstrb_q;
   assign cfg_bready_o   = bready_q;
   assign cfg_arvalid_o  = arvalid_q;
   assign cfg_araddr_o   = araddr_q;
   assign cfg_rready_o   = rready_q;

endmodule
`default_nettype wire
